// File: rtl/trash_pkg.sv
// Shared definitions for the trash CPU program store and its debug readback engine.
// Enabling READBACK_CHECKSUM_EN adds the SUM state to the readback state enum.
package trash_pkg;

  localparam int PROG_WORDS  = 8;
  localparam int PROG_ADDR_W = 3;
  localparam int PROG_WORD_W = 15;

  // Set in the first byte of every streamed word so a consumer can resync.
  localparam logic HDR_MARK = 1'b1;

  typedef enum logic [2:0] {
    RB_IDLE,
    RB_HI,
    RB_LO,
`ifdef READBACK_CHECKSUM_EN
    RB_SUM,
`endif
    RB_FIN
  } rb_state_e;

  function automatic logic [7:0] hi_byte(input logic [14:0] word);
    return {HDR_MARK, word[14:8]};
  endfunction

  function automatic logic [7:0] lo_byte(input logic [14:0] word);
    return word[7:0];
  endfunction

endpackage

// File: rtl/program_readback.sv
// Debug readback: snapshots the program store on start and streams each word as a
// {mark, hi7} / lo8 byte pair over valid/ready. READBACK_CHECKSUM_EN appends an XOR byte.
module program_readback
  import trash_pkg::*;
#(
  parameter int WORDS  = PROG_WORDS,
  parameter int ADDR_W = PROG_ADDR_W,
  parameter int WORD_W = PROG_WORD_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WORDS*WORD_W-1:0] prog_mem,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  rb_state_e               state_q;
  logic [WORDS*WORD_W-1:0] snap_q;
  logic [ADDR_W-1:0]       idx_q;
  logic [7:0]              out_data_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    done_q;
`ifdef READBACK_CHECKSUM_EN
  logic [7:0]              acc_q;
`endif

  logic              hs;
  logic [ADDR_W-1:0] idx_next;
  logic [14:0]       first_word;
  logic [14:0]       cur_word;
  logic [14:0]       next_word;

  assign hs         = out_valid_q && out_ready;
  assign idx_next   = idx_q + ADDR_W'(1);
  // Word 0 comes straight from the live memory so the first byte is ready one cycle after start.
  assign first_word = 15'(prog_mem[WORD_W-1:0]);
  assign cur_word   = 15'(snap_q[idx_q*WORD_W +: WORD_W]);
  assign next_word  = 15'(snap_q[idx_next*WORD_W +: WORD_W]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RB_IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        RB_IDLE: begin
          if (start) begin
            snap_q      <= prog_mem;
            idx_q       <= '0;
            state_q     <= RB_HI;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b1;
            out_data_q  <= hi_byte(first_word);
`ifdef READBACK_CHECKSUM_EN
            acc_q       <= '0;
`endif
          end
        end
        RB_HI: begin
          if (hs) begin
`ifdef READBACK_CHECKSUM_EN
            acc_q      <= acc_q ^ out_data_q;
`endif
            out_data_q <= lo_byte(cur_word);
            state_q    <= RB_LO;
          end
        end
        RB_LO: begin
          if (hs) begin
`ifdef READBACK_CHECKSUM_EN
            acc_q <= acc_q ^ out_data_q;
`endif
            if (idx_q == ADDR_W'(WORDS - 1)) begin
`ifdef READBACK_CHECKSUM_EN
              // The checksum byte covers every byte emitted, including this last LO byte.
              out_data_q  <= acc_q ^ out_data_q;
              state_q     <= RB_SUM;
`else
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= RB_FIN;
`endif
            end else begin
              idx_q      <= idx_next;
              out_data_q <= hi_byte(next_word);
              state_q    <= RB_HI;
            end
          end
        end
`ifdef READBACK_CHECKSUM_EN
        RB_SUM: begin
          if (hs) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= RB_FIN;
          end
        end
`endif
        RB_FIN: begin
          state_q <= RB_IDLE;
        end
        default: begin
          state_q <= RB_IDLE;
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_program_readback.sv
// Directed bench for program_readback: basic dump, backpressure, snapshot, ignored start,
// reset mid-dump and (with READBACK_CHECKSUM_EN) the trailing checksum byte.
module tb_program_readback;
  import trash_pkg::*;

  localparam int W  = PROG_WORDS;
  localparam int WW = PROG_WORD_W;
`ifdef READBACK_CHECKSUM_EN
  localparam int NB = 2 * W + 1;
`else
  localparam int NB = 2 * W;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [W*WW-1:0] prog_mem;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            done;

  int tests = 0;
  int fails = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int done_cnt;
  int done_cyc;
  int last_acc;

  always #5 clk = ~clk;

  program_readback dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .prog_mem (prog_mem),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference stream: {1, w[14:8]}, w[7:0] per word, then the XOR of all bytes when enabled.
  task automatic build_exp(input logic [W*WW-1:0] mem);
    logic [14:0] w;
    logic [7:0]  x;
    x = 8'h00;
    exp_q.delete();
    for (int i = 0; i < W; i++) begin
      w = mem[i*WW +: WW];
      exp_q.push_back({1'b1, w[14:8]});
      exp_q.push_back(w[7:0]);
      x = x ^ {1'b1, w[14:8]} ^ w[7:0];
    end
`ifdef READBACK_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("valid_latency1", 32'(out_valid), 32'd1);
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Consume bytes until done, optionally with a 1,0,0,1 ready pattern and a stray start pulse.
  task automatic run_dump(input bit bp, input int start_at);
    int         cyc;
    bit         stall;
    bit         fin;
    logic [7:0] held;
    cyc = 0; stall = 1'b0; fin = 1'b0; held = 8'h00;
    got.delete();
    done_cnt = 0; done_cyc = -1; last_acc = -1;
    while (!fin && cyc < 300) begin
      start = (cyc == start_at);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        fin = 1'b1;
      end else begin
        if (stall) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_data", 32'(out_data), 32'(held));
        end
        out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        stall = out_valid && !out_ready;
        held  = out_data;
        if (out_valid && out_ready) begin
          got.push_back(out_data);
          last_acc = cyc;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (!fin) chk("dump_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_dump(input string name);
    $display("[TB] dump %s: %0d bytes, done at cycle %0d", name, got.size(), done_cyc);
    chk({name, "_count"}, 32'(got.size()), 32'(NB));
    chk({name, "_done_lat"}, 32'(done_cyc), 32'(last_acc + 1));
    for (int i = 0; i < NB && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
    @(posedge clk); #1;
    chk({name, "_done_low"}, 32'(done), 32'd0);
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
    chk({name, "_valid_low"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [W*WW-1:0] mem_a;
    logic [W*WW-1:0] mem_b;
    logic [W*WW-1:0] mem_c;

    mem_a = '0;
    mem_a[WW-1:0] = 15'h1234;
    mem_b = '0;
    for (int i = 0; i < W; i++) mem_b[i*WW +: WW] = 15'h1234;
    mem_c = '0;
    for (int i = 0; i < W; i++) mem_c[i*WW +: WW] = 15'(16'h1111 * (i + 1));

    reset = 1'b1; start = 1'b0; out_ready = 1'b0; prog_mem = mem_a;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic dump, hand values for the leading bytes
    build_exp(mem_a);
    pulse_start();
    run_dump(1'b0, -1);
    chk("basic_b0", 32'(got.size() > 0 ? got[0] : 8'hxx), 32'h92);
    chk("basic_b1", 32'(got.size() > 1 ? got[1] : 8'hxx), 32'h34);
    chk("basic_b2", 32'(got.size() > 2 ? got[2] : 8'hxx), 32'h80);
    chk("basic_b15", 32'(got.size() > 15 ? got[15] : 8'hxx), 32'h00);
`ifdef READBACK_CHECKSUM_EN
    chk("basic_sum", 32'(got.size() > 16 ? got[16] : 8'hxx), 32'h26);
`endif
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);
    check_dump("basic");

    // Backpressure
    pulse_start();
    run_dump(1'b1, -1);
    check_dump("backpressure");

    // Snapshot isolation: memory changes right after the start cycle
    prog_mem = mem_a;
    pulse_start();
    prog_mem[WW-1:0] = 15'h7FFF;
    run_dump(1'b0, -1);
    check_dump("snapshot");

    // Second start mid-dump is ignored
    prog_mem = mem_a;
    pulse_start();
    run_dump(1'b0, 6);
    chk("restart_done_cnt", 32'(done_cnt), 32'd1);
    check_dump("restart");

    // Reset after the 5th byte
    pulse_start();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    // reset and start together: reset wins
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_valid", 32'(out_valid), 32'd0);
    chk("rst_start_busy", 32'(busy), 32'd0);
    pulse_start();
    run_dump(1'b0, -1);
    check_dump("after_reset");

    // All words 0x1234: checksum byte is 0x00 when enabled
    prog_mem = mem_b;
    build_exp(mem_b);
    pulse_start();
    run_dump(1'b0, -1);
    chk("allsame_b14", 32'(got.size() > 14 ? got[14] : 8'hxx), 32'h92);
`ifdef READBACK_CHECKSUM_EN
    chk("allsame_sum", 32'(got.size() > 16 ? got[16] : 8'hxx), 32'h00);
`endif
    check_dump("allsame");

    // Distinct words exercise the word ordering
    prog_mem = mem_c;
    build_exp(mem_c);
    pulse_start();
    run_dump(1'b1, -1);
    chk("distinct_b2", 32'(got.size() > 2 ? got[2] : 8'hxx), 32'hA2);
    chk("distinct_b3", 32'(got.size() > 3 ? got[3] : 8'hxx), 32'h22);
    check_dump("distinct");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/program_readback.md
Name: program_readback

Overview:
Debug readback engine for the 8-word program store of the trash CPU. It is the reader-side counterpart of the 15-bit programming port.
On request it snapshots the program memory and streams every word out as byte pairs over an 8-bit valid/ready channel, ordered word 0 to word WORDS-1. It sits beside the program memory and feeds the top-level dedicated outputs during debug.

Parameters:
WORDS, 8, number of program words streamed (power of two)
ADDR_W, 3, word index width, equals log2(WORDS)
WORD_W, 15, program word width; bits above WORD_W-1 in the framing are zero

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a dump
prog_mem  input  WORDS*WORD_W  flat program memory; word i at [i*WORD_W +: WORD_W]
out_data  output  8  streamed byte
out_valid  output  1  out_data holds a valid byte
out_ready  input  1  consumer accepts the byte when high together with out_valid
busy  output  1  dump in progress
done  output  1  one-cycle pulse after the final byte is accepted

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset); all state updates on the rising edge of clk.
- Reset values: out_data=0, out_valid=0, busy=0, done=0, state=IDLE, word index=0.
- FSM states: IDLE, HI, LO, SUM (only with the optional feature), FIN.
- IDLE, start=1:
  - snapshot prog_mem into an internal register;
  - index <= 0, state <= HI, busy <= 1.
  - out_valid rises on the cycle after start (latency 1).
- HI: out_data = {1'b1, word[14:8]}. MSB=1 marks the first byte of a word.
- LO: out_data = word[7:0].
- Transitions occur only on handshake (out_valid && out_ready):
  - HI -> LO;
  - LO -> HI with index+1;
  - LO at index WORDS-1 -> FIN, or -> SUM when the optional feature is enabled.
- Back-to-back: with out_ready held high, one byte is accepted per cycle; a full dump is 2*WORDS cycles of accepted bytes.
- Stall: while out_valid=1 and out_ready=0, out_data and out_valid stay stable. out_valid never drops without a handshake, except on reset.
- FIN lasts one cycle: done=1, busy=0, out_valid=0, then IDLE. The next start is accepted in IDLE only.
- start while busy or in FIN is ignored. It does not restart or queue a dump.
- Snapshot isolation: prog_mem changes after the start cycle do not affect the emitted bytes.
- Index wrap: the index never exceeds WORDS-1. The dump terminates; it does not wrap to word 0.
- Reset mid-dump: on the same edge, out_valid=0, busy=0, done=0 and state=IDLE. No partial byte is held over.
- reset and start in the same cycle: reset wins and no dump starts.

Optional Feature:
- Macro: READBACK_CHECKSUM_EN.
- Defined:
  - after the last LO byte, state SUM emits one byte equal to the XOR of all 2*WORDS bytes already emitted, with normal valid/ready rules;
  - done follows its handshake;
  - a full dump is 2*WORDS+1 bytes.
- Undefined: no SUM state and no accumulator logic; LO at the last word goes directly to FIN.

Decomposition:
- Shared package (trash_pkg), used by this block and the CPU top: PROG_WORDS=8, PROG_ADDR_W=3, PROG_WORD_W=15, the byte-framing constant HDR_MARK=1'b1, and the readback state enum.
- No sub-module: FSM, snapshot register and checksum accumulator fit in one module.

Test Plan:
- Basic dump: word0=15'h1234, others 0, out_ready=1, pulse start.
  - Expected bytes: 0x92, 0x34, then 0x80, 0x00 ×7.
  - done pulses exactly one cycle after the 16th accept; busy is low afterwards.
- Backpressure: out_ready toggled 1,0,0,1 repeatedly.
  - out_data is stable across stalls; the byte sequence is identical to the basic dump; no byte is dropped or duplicated.
- Snapshot: change word0 to 15'h7FFF the cycle after start.
  - First bytes are still 0x92, 0x34.
- start while busy: a second start pulse mid-dump.
  - Ignored; exactly 16 bytes; a single done pulse.
- Reset mid-dump: assert reset after the 5th byte.
  - Next cycle out_valid=0, busy=0.
  - A new start yields a full dump from word 0.
- Checksum (READBACK_CHECKSUM_EN): memory all 15'h1234.
  - 16 bytes as above, then a 17th byte 0x00; done follows that byte's handshake.
  - Word0 only =15'h1234: 17th byte = 0x92^0x34^(0x80 XOR ×7) = 0x26.
